// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkg
// Purpose  : Shared sizing helpers for the AXI-Stream register-slice pipeline.
//            A beat is packed as {last, user, data}, with data in the LSBs.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axis_pkg;

    // Occupancy counter width able to represent 0 .. 2*depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

    // Packed beat width for the {last, user, data} layout.
    function automatic int beat_w(input int dw, input int uw);
        return dw + uw + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_if
// Purpose  : AXI-Stream bundle (TVALID/TREADY/TDATA/TUSER/TLAST).
// Ports    : master modport drives valid/payload and samples ready;
//            slave modport samples valid/payload and drives ready.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_if #(
    parameter int DW = 16,
    parameter int UW = 1
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast,
                    input  tready);
    modport slave  (input  tvalid, input  tdata, input  tuser, input  tlast,
                    output tready);
endinterface
`default_nettype wire

// File: rtl/axis_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_stage
// Purpose  : One full-throughput skid-buffer stage. A main register feeds the
//            output; a skid register catches the beat accepted in the cycle
//            the output stalls. Upstream ready is registered (!skid_valid).
// Ports    : clk, rst (async, active-high)
//            s_axis - upstream stream (slave modport)
//            m_axis - downstream stream (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module axis_skid_stage
    import axis_pkg::*;
#(
    parameter int DW           = 16,
    parameter int UW           = 1,
    parameter int OPT_LOWPOWER = 0
) (
    input  wire logic clk,
    input  wire logic rst,
    axis_if.slave     s_axis,
    axis_if.master    m_axis
);
    localparam int BW = beat_w(DW, UW);

    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          ready_q, ready_d;
    logic [BW-1:0] main_q, main_d;
    logic [BW-1:0] skid_q, skid_d;

    logic [BW-1:0] w_in_beat;
    logic          w_in_fire;
    logic          w_load;

    assign w_in_beat = {s_axis.tlast, s_axis.tuser, s_axis.tdata};
    assign w_in_fire = s_axis.tvalid & ready_q;
    // Main register may take a new beat when empty or being drained.
    assign w_load    = !out_valid_q || m_axis.tready;

    always_comb begin
        out_valid_d  = out_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (w_load) begin
            if (skid_valid_q) begin
                // Skid holds the older beat: it must go out first.
                out_valid_d  = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
                if (OPT_LOWPOWER != 0) begin
                    skid_d = '0;
                end
            end else begin
                out_valid_d = w_in_fire;
                main_d      = w_in_beat;
                if ((OPT_LOWPOWER != 0) && !w_in_fire) begin
                    main_d = '0;
                end
            end
        end else if (w_in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = w_in_beat;
        end
        // Ready looks only at local state, never at downstream ready.
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign s_axis.tready = ready_q;
    assign m_axis.tvalid = out_valid_q;
    assign {m_axis.tlast, m_axis.tuser, m_axis.tdata} = main_q;

endmodule
`default_nettype wire

// File: rtl/axis_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : axis_pipeline
// Purpose  : DEPTH skid stages in series forming a 1 beat/cycle AXI-Stream
//            register slice with registered TVALID/TREADY at every stage and
//            an occupancy counter (0 .. 2*DEPTH).
// Ports    : S_AXI_ACLK   - clock
//            S_AXI_ARESET - async active-high reset
//            S_AXIS       - upstream stream (slave modport)
//            M_AXIS       - downstream stream (master modport)
//            o_occupancy  - beats currently held
// Revision : 1.0 - initial release
// ============================================================================
module axis_pipeline
    import axis_pkg::*;
#(
    parameter int DW           = 16,
    parameter int UW           = 1,
    parameter int DEPTH        = 2,
    parameter int OPT_LOWPOWER = 0
) (
    input  wire logic                    S_AXI_ACLK,
    input  wire logic                    S_AXI_ARESET,
    axis_if.slave                        S_AXIS,
    axis_if.master                       M_AXIS,
    output logic [occ_w(DEPTH)-1:0]      o_occupancy
);
    localparam int OW = occ_w(DEPTH);

    // Link k feeds stage k; link DEPTH is the output of the last stage.
    axis_if #(.DW(DW), .UW(UW)) w_link [0:DEPTH] ();

    assign w_link[0].tvalid = S_AXIS.tvalid;
    assign w_link[0].tdata  = S_AXIS.tdata;
    assign w_link[0].tuser  = S_AXIS.tuser;
    assign w_link[0].tlast  = S_AXIS.tlast;
    assign S_AXIS.tready    = w_link[0].tready;

    assign M_AXIS.tvalid        = w_link[DEPTH].tvalid;
    assign M_AXIS.tdata         = w_link[DEPTH].tdata;
    assign M_AXIS.tuser         = w_link[DEPTH].tuser;
    assign M_AXIS.tlast         = w_link[DEPTH].tlast;
    assign w_link[DEPTH].tready = M_AXIS.tready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        axis_skid_stage #(
            .DW           (DW),
            .UW           (UW),
            .OPT_LOWPOWER (OPT_LOWPOWER)
        ) u_stage (
            .clk    (S_AXI_ACLK),
            .rst    (S_AXI_ARESET),
            .s_axis (w_link[i]),
            .m_axis (w_link[i+1])
        );
    end

    logic          w_in_fire;
    logic          w_out_fire;
    logic [OW-1:0] occ_q, occ_d;

    assign w_in_fire  = S_AXIS.tvalid & w_link[0].tready;
    assign w_out_fire = w_link[DEPTH].tvalid & M_AXIS.tready;

    always_comb begin
        occ_d = occ_q;
        if (w_in_fire && !w_out_fire) begin
            occ_d = occ_q + OW'(1);
        end else if (!w_in_fire && w_out_fire) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign o_occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pipeline
// Purpose  : Self-checking bench driving three pipeline configurations
//            (DEPTH=2, DEPTH=3 low-power, DEPTH=1) with a shared stimulus
//            policy; each configuration is compared against a FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pipeline;
    localparam int DW   = 16;
    localparam int UW   = 2;
    localparam int BW   = DW + UW + 1;
    localparam int NCFG = 3;

    function automatic int dep(input int g);
        case (g)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          s_valid [NCFG];
    logic [DW-1:0] s_data  [NCFG];
    logic [UW-1:0] s_user  [NCFG];
    logic          s_last  [NCFG];
    logic          m_ready;

    logic          w_s_tready [NCFG];
    logic          w_m_tvalid [NCFG];
    logic [DW-1:0] w_m_tdata  [NCFG];
    logic [UW-1:0] w_m_tuser  [NCFG];
    logic          w_m_tlast  [NCFG];
    logic [4:0]    w_occ      [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int D  = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
        localparam int LP = (g == 1) ? 1 : 0;
        localparam int OW = $clog2(2 * D + 1);
        logic [OW-1:0] occ;
        axis_if #(.DW(DW), .UW(UW)) s_if ();
        axis_if #(.DW(DW), .UW(UW)) m_if ();

        assign s_if.tvalid = s_valid[g];
        assign s_if.tdata  = s_data[g];
        assign s_if.tuser  = s_user[g];
        assign s_if.tlast  = s_last[g];
        assign m_if.tready = m_ready;

        axis_pipeline #(
            .DW(DW), .UW(UW), .DEPTH(D), .OPT_LOWPOWER(LP)
        ) u_dut (
            .S_AXI_ACLK   (clk),
            .S_AXI_ARESET (rst),
            .S_AXIS       (s_if),
            .M_AXIS       (m_if),
            .o_occupancy  (occ)
        );

        assign w_s_tready[g] = s_if.tready;
        assign w_m_tvalid[g] = m_if.tvalid;
        assign w_m_tdata[g]  = m_if.tdata;
        assign w_m_tuser[g]  = m_if.tuser;
        assign w_m_tlast[g]  = m_if.tlast;
        assign w_occ[g]      = 5'(occ);
    end

    // Behavioural model: one FIFO of accepted beats per configuration.
    logic [BW-1:0] mem [NCFG][64];
    int            head      [NCFG];
    int            tail      [NCFG];
    int            idx       [NCFG];
    int            out_total [NCFG];
    int            first_in  [NCFG];
    int            first_vld [NCFG];
    int            last_out  [NCFG];
    logic          prev_stall[NCFG];
    logic [BW:0]   prev_beat [NCFG];
    int            bo        [NCFG];
    int            bi        [NCFG];

    int cyc;
    int mode;      // 0 stream, 1 stall, 2 random, 3 alternate ready, 4 idle
    int limit;
    bit force_ff;
    int n_tests;
    int n_fail;

    task automatic chk(input string name, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d: got %0h expected %0h", name, g, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int g = 0; g < NCFG; g++) begin
            head[g]       = 0;
            tail[g]       = 0;
            idx[g]        = 0;
            out_total[g]  = 0;
            first_in[g]   = -1;
            first_vld[g]  = -1;
            last_out[g]   = -1;
            prev_stall[g] = 1'b0;
            prev_beat[g]  = '0;
        end
    endtask

    task automatic monitor();
        for (int g = 0; g < NCFG; g++) begin
            logic          in_f;
            logic          out_f;
            logic [BW-1:0] ob;
            int            cnt;
            in_f = s_valid[g] & w_s_tready[g];
            out_f = w_m_tvalid[g] & m_ready;
            ob = {w_m_tlast[g], w_m_tuser[g], w_m_tdata[g]};
            cnt = tail[g] - head[g];
            chk("occupancy", g, 32'(w_occ[g]), 32'(cnt));
            if (cnt == 2 * dep(g)) chk("full_ready", g, 32'(w_s_tready[g]), 32'd0);
            if (w_m_tvalid[g]) begin
                if (cnt == 0) chk("stale_beat", g, 32'(w_m_tvalid[g]), 32'd0);
                else chk("beat", g, 32'(ob), 32'(mem[g][6'(head[g])]));
            end
            if (prev_stall[g]) chk("stable", g, 32'({w_m_tvalid[g], ob}), 32'(prev_beat[g]));
            if (g == 1 && !w_m_tvalid[g]) chk("lowpower_idle", g, 32'(ob), 32'd0);
            prev_stall[g] = w_m_tvalid[g] & ~m_ready;
            prev_beat[g]  = {w_m_tvalid[g], ob};
            if (w_m_tvalid[g] && first_vld[g] < 0) first_vld[g] = cyc;
            if (out_f) begin
                head[g]++;
                out_total[g]++;
                last_out[g] = cyc;
            end
            if (in_f) begin
                mem[g][6'(tail[g])] = {s_last[g], s_user[g], s_data[g]};
                tail[g]++;
                idx[g]++;
                if (first_in[g] < 0) first_in[g] = cyc;
            end
        end
    endtask

    task automatic drive();
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            2:       m_ready = ($urandom_range(0, 9) < 3);
            3:       m_ready = ~m_ready;
            default: m_ready = 1'b1;
        endcase
        for (int g = 0; g < NCFG; g++) begin
            logic v;
            v = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode != 4);
            s_valid[g] = v && (idx[g] < limit);
            s_data[g]  = force_ff ? 16'hFFFF : idx[g][DW-1:0];
            s_user[g]  = idx[g][UW-1:0];
            s_last[g]  = (idx[g] % 8 == 7);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst) monitor();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        mode  = 4;
        limit = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        rst = 1'b0;
        cyc = 0;
        m_ready = 1'b1;
        drive();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        mode     = 4;
        limit    = 0;
        force_ff = 1'b0;
        m_ready  = 1'b1;
        reset_model();
        drive();
        #2 rst = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            chk("rst_tready", g, 32'(w_s_tready[g]), 32'd0);
            chk("rst_tvalid", g, 32'(w_m_tvalid[g]), 32'd0);
            chk("rst_occ",    g, 32'(w_occ[g]),      32'd0);
            chk("rst_data",   g, 32'({w_m_tlast[g], w_m_tuser[g], w_m_tdata[g]}), 32'd0);
        end

        // Full-rate streaming of 64 beats
        do_reset();
        mode  = 0;
        limit = 64;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (i == 30) begin
                for (int g = 0; g < NCFG; g++)
                    chk("occ_steady", g, 32'(w_occ[g]), 32'(dep(g)));
            end
        end
        chk("occ_steady_d2", 0, 32'(w_occ[0]), 32'd0);
        for (int g = 0; g < NCFG; g++) begin
            chk("stream_count",   g, 32'(out_total[g]), 32'd64);
            chk("stream_latency", g, 32'(first_vld[g] - first_in[g]), 32'(dep(g)));
            chk("stream_no_gaps", g, 32'(last_out[g] - first_vld[g] + 1), 32'd64);
        end

        // Stall until full, then drain without gaps
        do_reset();
        mode  = 1;
        limit = 1000;
        repeat (20) cycle();
        for (int g = 0; g < NCFG; g++) begin
            chk("stall_accepted", g, 32'(idx[g]),        32'(2 * dep(g)));
            chk("stall_tready",   g, 32'(w_s_tready[g]), 32'd0);
            chk("stall_occ",      g, 32'(w_occ[g]),      32'(2 * dep(g)));
            bo[g] = out_total[g];
        end
        mode = 4;
        for (int j = 1; j <= 7; j++) begin
            cycle();
            for (int g = 0; g < NCFG; g++)
                if (j - 1 <= 2 * dep(g))
                    chk("drain_rate", g, 32'(out_total[g] - bo[g]), 32'(j - 1));
        end
        repeat (4) cycle();

        // Randomised traffic, 10000 beats per configuration
        do_reset();
        mode  = 2;
        limit = 10000;
        for (int i = 0; i < 60000; i++) begin
            cycle();
            if (out_total[0] >= 10000 && out_total[1] >= 10000 && out_total[2] >= 10000)
                break;
        end
        for (int g = 0; g < NCFG; g++) begin
            chk("random_count", g, 32'(out_total[g]), 32'd10000);
            chk("random_empty", g, 32'(w_occ[g]),     32'd0);
        end

        // Asynchronous reset with beats held
        do_reset();
        mode  = 1;
        limit = 4;
        repeat (10) cycle();
        for (int g = 0; g < NCFG; g++) begin
            chk("held_occ",    g, 32'(w_occ[g]), 32'((2 * dep(g) < 4) ? 2 * dep(g) : 4));
            chk("held_tvalid", g, 32'(w_m_tvalid[g]), 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < NCFG; g++) begin
            chk("async_tvalid", g, 32'(w_m_tvalid[g]), 32'd0);
            chk("async_tready", g, 32'(w_s_tready[g]), 32'd0);
            chk("async_occ",    g, 32'(w_occ[g]),      32'd0);
        end
        reset_model();
        @(posedge clk);
        #3 rst = 1'b0;
        mode  = 0;
        limit = 8;
        @(posedge clk);
        #1;
        for (int g = 0; g < NCFG; g++)
            chk("release_tready", g, 32'(w_s_tready[g]), 32'd1);
        drive();
        repeat (40) cycle();
        for (int g = 0; g < NCFG; g++)
            chk("post_reset_count", g, 32'(out_total[g]), 32'd8);

        // Low-power payload clearing after an all-ones burst
        do_reset();
        force_ff = 1'b1;
        mode     = 0;
        limit    = 20;
        repeat (40) cycle();
        force_ff = 1'b0;
        chk("lp_burst_count", 1, 32'(out_total[1]), 32'd20);
        chk("lp_idle_valid",  1, 32'(w_m_tvalid[1]), 32'd0);
        chk("lp_idle_data",   1, 32'(w_m_tdata[1]),  32'd0);
        chk("lp_idle_last",   1, 32'(w_m_tlast[1]),  32'd0);

        // Downstream ready alternating every cycle
        do_reset();
        mode  = 3;
        limit = 1000;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (i == 20) begin
                for (int g = 0; g < NCFG; g++) begin
                    bo[g] = out_total[g];
                    bi[g] = idx[g];
                end
            end
            if (i == 60) begin
                for (int g = 0; g < NCFG; g++)
                    chk("alt_out_rate", g, 32'(out_total[g] - bo[g]), 32'd20);
                chk("alt_in_rate", 2, 32'(idx[2] - bi[2]), 32'd20);
            end
        end
        mode = 4;
        repeat (20) cycle();
        for (int g = 0; g < NCFG; g++)
            chk("alt_all_out", g, 32'(out_total[g]), 32'(idx[g]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/axis_pipeline.md
Name: axis_pipeline

Overview:
- Parametrised, full-throughput AXI-Stream register slice: a chain of DEPTH skid-buffer stages between slave and master ports.
- Generalises the earlier one-beat-every-other-cycle stream register. It sustains 1 beat/cycle, registers TREADY and TVALID at every stage, carries TUSER, and reports occupancy.
- Used to break timing paths on long stream routes between DSP and bus blocks.

Parameters:
- DW, 16, TDATA width in bits (>=1).
- UW, 1, TUSER width in bits (>=1).
- DEPTH, 2, number of skid stages in series (1..16).
- OPT_LOWPOWER, 0, when 1, data/user/last registers are forced to zero whenever their valid bit is 0.

Ports:
- S_AXI_ACLK  in  1  clock; all logic on rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TVALID  in  1  upstream beat valid.
- S_AXIS_TREADY  out  1  registered ready to upstream.
- S_AXIS_TDATA  in  DW  upstream data.
- S_AXIS_TUSER  in  UW  upstream sideband.
- S_AXIS_TLAST  in  1  upstream end-of-packet.
- M_AXIS_TVALID  out  1  registered downstream valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  DW  downstream data.
- M_AXIS_TUSER  out  UW  downstream sideband.
- M_AXIS_TLAST  out  1  downstream end-of-packet.
- o_occupancy  out  $clog2(2*DEPTH+1)  beats currently held in the pipeline.

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Reset S_AXI_ARESET is asynchronous and active-high. Assertion immediately clears every stage.
- Reset values:
  - All stage valid and skid-valid bits are 0.
  - S_AXIS_TREADY = 0, M_AXIS_TVALID = 0, o_occupancy = 0.
  - Data, user and last registers are 0.
- After reset release: S_AXIS_TREADY rises on the first clock edge after S_AXI_ARESET deasserts.
- Each stage has a main register (out_valid plus payload) and a skid register (skid_valid plus payload). Stage ready to its upstream is the registered value of !skid_valid.
- Stage update per clock, with in_fire = in_valid & in_ready and out_fire = out_valid & out_ready:
  - !out_valid or out_ready, and skid_valid: main <= skid; skid_valid <= 0.
  - !out_valid or out_ready, and !skid_valid: main <= input; out_valid <= in_valid.
  - out_valid and !out_ready and in_fire: skid <= input; skid_valid <= 1; ready drops next cycle.
  - in_ready is combinationally independent of out_ready. No combinational path exists from any M_* input to any S_* output.
- Latency: an accepted beat appears on M_AXIS_* DEPTH cycles after S_AXIS handshake when M_AXIS_TREADY is held high.
- Throughput: 1 beat/cycle sustained with M_AXIS_TREADY high. There are no bubbles.
- Ordering: strict FIFO order. TDATA, TUSER and TLAST of each beat travel together.
- Capacity: 2*DEPTH beats maximum.
- Stall: with M_AXIS_TREADY held low, S_AXIS_TREADY falls after the pipeline has absorbed 2*DEPTH beats. No beat is dropped or duplicated.
- AXI-Stream rules:
  - Once M_AXIS_TVALID is 1 and M_AXIS_TREADY is 0, M_AXIS_TVALID/TDATA/TUSER/TLAST stay stable next cycle.
  - TVALID never depends on TREADY.
- o_occupancy: registered. It increments on S_AXIS handshake, decrements on M_AXIS handshake, and is unchanged when both fire in the same cycle. It never exceeds 2*DEPTH and never underflows.
- OPT_LOWPOWER=1: any payload register whose valid is 0 holds all zeros, including M_AXIS_TDATA/TUSER/TLAST whenever M_AXIS_TVALID = 0.
- Reset mid-packet: all held beats are discarded and o_occupancy returns to 0. No partial packet is emitted after release.

Decomposition:
- Shared package axis_pkg:
  - localparam helper function clog2-based OCC_W(depth).
  - AXI-Stream beat struct layout {last, user, data} packing widths.
- One natural sub-module: axis_skid_stage.
  - Parameters DW, UW, OPT_LOWPOWER.
  - Ports: clock, reset, one input and one output stream interface.
  - axis_pipeline instantiates DEPTH copies in a generate loop and owns the occupancy counter.

Test Plan:
- Stream 64 beats (TDATA = 0..63, TLAST on every 8th) with M_AXIS_TREADY=1 and DEPTH=2 -> first beat out 2 cycles after acceptance, 64 consecutive output cycles, identical data/last order, o_occupancy steady at 2.
- Hold M_AXIS_TREADY=0 and drive TVALID continuously with DEPTH=3 -> exactly 6 beats accepted, then S_AXIS_TREADY=0, o_occupancy=6. Release ready -> beats 0..5 emerge in order with no gaps.
- Random TVALID (50%) and random M_AXIS_TREADY (30%), 10000 beats with TUSER=beat index mod 2^UW -> scoreboard match. Stability assertion on the stalled master holds. o_occupancy always equals the scoreboard depth.
- Assert S_AXI_ARESET asynchronously mid-cycle with 4 beats held -> M_AXIS_TVALID and S_AXIS_TREADY drop without waiting for a clock edge, o_occupancy=0. After release, S_AXIS_TREADY=1 at the next edge and no stale beat appears.
- OPT_LOWPOWER=1, idle after a burst of TDATA=16'hFFFF -> M_AXIS_TDATA=0 and M_AXIS_TLAST=0 whenever M_AXIS_TVALID=0.
- DEPTH=1, alternating M_AXIS_TREADY 1/0 every cycle with TVALID held high -> throughput is 1 beat per 2 cycles and no beat is lost. S_AXIS_TREADY toggles only as the skid register fills and drains.
